seed_round_ctrl: RTL and testbench

Round sequencer for the SEED encryption core; sits directly downstream of the clock-enable pulse generator. It consumes the `clk_en` pulse train and steps the datapath through the 16 SEED rounds, one round per pulse. It produces round index, load, round-enable and last-round strobes for the Feistel datapath and key schedule, and reports completion through a done/ack handshake.

---
 rtl/seed_pkg.sv | 15 +
 rtl/seed_round_ctrl.sv | 89 ++++++++
 tb/tb_seed_round_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seed_pkg.sv
// Shared SEED core definitions: round count, counter width, sequencer states.
// Reused by the round controller, key schedule and Feistel datapath.
package seed_pkg;

  localparam int SEED_ROUNDS = 16;
  localparam int SEED_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_ROUND = 2'b10,
    ST_DONE  = 2'b11
  } seed_state_e;

endpackage

// File: rtl/seed_round_ctrl.sv
// SEED round sequencer: one Feistel round per clk_en pulse, done/ack release.
// Ports: clk, reset (async high), start, clk_en, decrypt, ack in;
//        load, round_en, last_round, round_idx[CNT_W], busy, done out.
module seed_round_ctrl
  import seed_pkg::*;
#(
  parameter int ROUNDS = SEED_ROUNDS,
  parameter int CNT_W  = SEED_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clk_en,
  input  logic             decrypt,
  input  logic             ack,
  output logic             load,
  output logic             round_en,
  output logic             last_round,
  output logic [CNT_W-1:0] round_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  seed_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_q, dec_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dec_d      = dec_q;
    load       = 1'b0;
    round_en   = 1'b0;
    last_round = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          dec_d   = decrypt;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        busy    = 1'b1;
        cnt_d   = '0;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        busy = 1'b1;
        // No pulse means a stall: state and count simply hold.
        if (clk_en) begin
          round_en = 1'b1;
          if (cnt_q == LAST) begin
            last_round = 1'b1;
            state_d    = ST_DONE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decrypt walks the key schedule backwards.
  assign round_idx = dec_q ? (LAST - cnt_q) : cnt_q;

endmodule

// File: tb/tb_seed_round_ctrl.sv
// Scoreboard bench for seed_round_ctrl: stimulus queues expected events,
// a negedge monitor pops and compares on load, round_en and done rise.
module tb_seed_round_ctrl;
  import seed_pkg::*;

  localparam logic [1:0] K_LOAD = 2'd0;
  localparam logic [1:0] K_RND  = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] idx;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, start, clk_en, decrypt, ack;
  logic       load, round_en, last_round, busy, done;
  logic [3:0] round_idx;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  seed_round_ctrl #(.ROUNDS(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .clk_en(clk_en),
    .decrypt(decrypt), .ack(ack), .load(load), .round_en(round_en),
    .last_round(last_round), .round_idx(round_idx), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic pop_cmp(input logic [1:0] kind, input string name);
    exp_t e;
    if (q.size() == 0) begin
      chk({"unexpected_", name}, 1, 0);
    end else begin
      e = q.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      if (kind == K_RND) begin
        chk("round_idx", round_idx, e.idx);
        chk("last_round", last_round, e.last);
      end
    end
  endtask

  // Monitor
  initial begin
    logic done_d;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (last_round && !round_en) chk("last_alone", 1, 0);
      if (load) pop_cmp(K_LOAD, "load");
      if (round_en) pop_cmp(K_RND, "round");
      if (done && !done_d) pop_cmp(K_DONE, "done");
      done_d = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic dec, input bit load_pulse,
                     input int stall_after, input bit toggle,
                     input int abort_at, input bit ce_with_ack);
    int   n;
    exp_t e;
    n = (abort_at >= 0) ? abort_at : 16;
    e = '{K_LOAD, 4'd0, 1'b0};
    q.push_back(e);
    for (int i = 0; i < n; i++) begin
      e = '{K_RND, (dec ? 4'(15 - i) : 4'(i)), (i == 15)};
      q.push_back(e);
    end
    if (abort_at < 0) begin
      e = '{K_DONE, 4'd0, 1'b0};
      q.push_back(e);
    end
    start   = 1'b1;
    decrypt = dec;
    tick();
    chk("busy_load", busy, 1);
    clk_en = load_pulse;
    tick();
    clk_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (abort_at == i) begin
        chk("idx_pre_abort", round_idx, i);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_idx", round_idx, 0);
        chk("abort_done", done, 0);
        chk("abort_round_en", round_en, 0);
        @(negedge clk);
        reset  = 1'b0;
        start  = 1'b0;
        clk_en = 1'b0;
        tick();
        return;
      end
      repeat (3) tick();
      clk_en = 1'b1;
      if (toggle && i == 5) decrypt = ~dec;
      tick();
      clk_en = 1'b0;
      if (i + 1 == stall_after) begin
        start = 1'b0;
        repeat (20) tick();
        chk("stall_busy", busy, 1);
        chk("stall_idx", round_idx, dec ? 15 - (i + 1) : i + 1);
        start = 1'b1;
      end
    end
    chk("done_rise", done, 1);
    chk("busy_done", busy, 0);
    repeat (5) tick();
    chk("done_held", done, 1);
    chk("no_reload", load, 0);
    ack    = 1'b1;
    clk_en = ce_with_ack;
    tick();
    ack    = 1'b0;
    clk_en = 1'b0;
    start  = 1'b0;
    chk("done_released", done, 0);
    chk("busy_idle", busy, 0);
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    clk_en  = 1'b0;
    decrypt = 1'b0;
    ack     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst_load", load, 0);
    chk("rst_round_en", round_en, 0);
    chk("rst_last", last_round, 0);
    chk("rst_idx", round_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    // encrypt: pulse in LOAD, stall after round 7, pulse with ack
    run(1'b0, 1'b1, 8, 1'b0, -1, 1'b1);
    // decrypt with mid-run mode toggle
    run(1'b1, 1'b0, 0, 1'b1, -1, 1'b0);
    // async reset during round 10
    run(1'b0, 1'b0, 0, 1'b0, 10, 1'b0);
    // fresh encrypt after reset
    run(1'b0, 1'b0, 0, 1'b0, -1, 1'b0);
    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $finish;
  end

endmodule
